bt656_rx: RTL

- BT.656 byte-stream receiver; consumes the 8-bit data bus and pixel clock produced by the BT.656 transmitter stage.
- Oversamples the pixel clock in the system clock domain and captures one byte per pixel-clock rising edge.
- Detects the FF 00 00 XY timing reference codes, validates them, and recovers F/V/H.
- Delivers active-video bytes with a valid strobe, plus position counters, lock status and error flags.

---
 rtl/bt656_rx_if.sv | 35 +++
 rtl/bt656_rx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bt656_rx_if.sv
// BT.656 receiver bus: byte/pixel-clock inputs plus the decoded video outputs.
// Parameterised on HACT_BYTES so the pixel counter width tracks the line length.
interface bt656_rx_if #(
    parameter int HACT_BYTES = 22
);
    localparam int PCW = $clog2(HACT_BYTES + 1) + 1;

    logic           i_PixelClock;
    logic [7:0]     i_Data;
    logic [7:0]     o_Data;
    logic           o_DataValid;
    logic           o_Fsignal;
    logic           o_Vsignal;
    logic           o_Hsignal;
    logic           o_SavPulse;
    logic           o_EavPulse;
    logic [PCW-1:0] o_PixelCount;
    logic [11:0]    o_LineCount;
    logic           o_Locked;
    logic           o_SyncError;

    modport master (
        output i_PixelClock, i_Data,
        input  o_Data, o_DataValid, o_Fsignal, o_Vsignal, o_Hsignal,
        input  o_SavPulse, o_EavPulse, o_PixelCount, o_LineCount,
        input  o_Locked, o_SyncError
    );

    modport slave (
        input  i_PixelClock, i_Data,
        output o_Data, o_DataValid, o_Fsignal, o_Vsignal, o_Hsignal,
        output o_SavPulse, o_EavPulse, o_PixelCount, o_LineCount,
        output o_Locked, o_SyncError
    );
endinterface

// File: rtl/bt656_rx.sv
// BT.656 byte-stream receiver: oversampled pixel-clock capture, TRS decode,
// active-video strobe, counters and lock. Macro BT656_RX_PARITY_CHECK_EN adds XY protection-bit checking.
module bt656_rx #(
    parameter int SYS_CLOCK     = 50000000,
    parameter int PIXEL_CLOCK   = 12500000,
    parameter int HACT_BYTES    = 22,
    parameter int TIMEOUT_BYTES = 64
) (
    input  logic       i_SysClock,
    input  logic       i_Reset,
    bt656_rx_if.slave  bus
);
    localparam int PCW = $clog2(HACT_BYTES + 1) + 1;
    localparam int TW  = $clog2(TIMEOUT_BYTES + 1);

    if (SYS_CLOCK / PIXEL_CLOCK < 4) begin : g_ratio_check
        $error("bt656_rx: SYS_CLOCK/PIXEL_CLOCK must be >= 4");
    end

    typedef enum logic [2:0] {
        S_SEARCH,
        S_FF,
        S_FF00,
        S_XY,
        S_ACTIVE
    } state_t;

    state_t         state;
    logic           pclk_meta;
    logic           pclk_sync;
    logic           pclk_prev;
    logic [7:0]     data_d1;
    logic [7:0]     data_d2;
    logic           cap_stb;
    logic           xy_ok;
    logic [7:0]     data_q;
    logic           valid_q;
    logic           f_q;
    logic           v_q;
    logic           h_q;
    logic           sav_q;
    logic           eav_q;
    logic [PCW-1:0] pix_cnt;
    logic [11:0]    line_cnt;
    logic           locked_q;
    logic           err_q;
    logic           in_line;
    logic [TW-1:0]  tmo_cnt;

    // Synchronise the pixel clock and delay the byte bus by the same two stages.
    always_ff @(posedge i_SysClock or posedge i_Reset) begin
        if (i_Reset) begin
            pclk_meta <= 1'b0;
            pclk_sync <= 1'b0;
            pclk_prev <= 1'b0;
            data_d1   <= 8'h00;
            data_d2   <= 8'h00;
        end else begin
            pclk_meta <= bus.i_PixelClock;
            pclk_sync <= pclk_meta;
            pclk_prev <= pclk_sync;
            data_d1   <= bus.i_Data;
            data_d2   <= data_d1;
        end
    end

    assign cap_stb = pclk_sync & ~pclk_prev;

`ifdef BT656_RX_PARITY_CHECK_EN
    assign xy_ok = data_d2[7]
                 & (data_d2[3] == (data_d2[5] ^ data_d2[4]))
                 & (data_d2[2] == (data_d2[6] ^ data_d2[4]))
                 & (data_d2[1] == (data_d2[6] ^ data_d2[5]))
                 & (data_d2[0] == (data_d2[6] ^ data_d2[5] ^ data_d2[4]));
`else
    assign xy_ok = data_d2[7];
`endif

    // TRS decoder FSM with registered outputs; advances once per captured byte.
    always_ff @(posedge i_SysClock or posedge i_Reset) begin
        if (i_Reset) begin
            state    <= S_SEARCH;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            f_q      <= 1'b0;
            v_q      <= 1'b0;
            h_q      <= 1'b0;
            sav_q    <= 1'b0;
            eav_q    <= 1'b0;
            pix_cnt  <= '0;
            line_cnt <= 12'd0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            in_line  <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            valid_q <= 1'b0;
            sav_q   <= 1'b0;
            eav_q   <= 1'b0;
            err_q   <= 1'b0;
            if (cap_stb) begin
                if (tmo_cnt != TW'(TIMEOUT_BYTES))
                    tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_cnt == TW'(TIMEOUT_BYTES - 1))
                    locked_q <= 1'b0;
                unique case (state)
                    S_SEARCH: begin
                        if (data_d2 == 8'hFF)
                            state <= S_FF;
                    end
                    S_FF: begin
                        if (data_d2 == 8'h00)
                            state <= S_FF00;
                        else if (data_d2 != 8'hFF)
                            state <= S_SEARCH;
                    end
                    S_FF00: begin
                        if (data_d2 == 8'h00) begin
                            state <= S_XY;
                        end else begin
                            state <= S_SEARCH;
                            err_q <= 1'b1;
                        end
                    end
                    S_XY: begin
                        state   <= S_SEARCH;
                        in_line <= 1'b0;
                        if (xy_ok) begin
                            tmo_cnt  <= '0;
                            locked_q <= 1'b1;
                            f_q      <= data_d2[6];
                            v_q      <= data_d2[5];
                            h_q      <= data_d2[4];
                            if ((f_q != data_d2[6]) || (v_q && !data_d2[5]))
                                line_cnt <= 12'd0;
                            else if (data_d2[4] && in_line)
                                line_cnt <= line_cnt + 12'd1;
                            if (!data_d2[4]) begin
                                sav_q   <= 1'b1;
                                pix_cnt <= '0;
                                if (!data_d2[5]) begin
                                    state   <= S_ACTIVE;
                                    in_line <= 1'b1;
                                end
                            end else begin
                                eav_q <= 1'b1;
                                if (in_line && pix_cnt != PCW'(HACT_BYTES))
                                    err_q <= 1'b1;
                            end
                        end else begin
                            err_q    <= 1'b1;
                            locked_q <= 1'b0;
                        end
                    end
                    S_ACTIVE: begin
                        if (data_d2 == 8'hFF) begin
                            state <= S_FF;
                        end else begin
                            data_q  <= data_d2;
                            valid_q <= 1'b1;
                            if (pix_cnt != '1)
                                pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                    default: state <= S_SEARCH;
                endcase
            end
        end
    end

    assign bus.o_Data       = data_q;
    assign bus.o_DataValid  = valid_q;
    assign bus.o_Fsignal    = f_q;
    assign bus.o_Vsignal    = v_q;
    assign bus.o_Hsignal    = h_q;
    assign bus.o_SavPulse   = sav_q;
    assign bus.o_EavPulse   = eav_q;
    assign bus.o_PixelCount = pix_cnt;
    assign bus.o_LineCount  = line_cnt;
    assign bus.o_Locked     = locked_q;
    assign bus.o_SyncError  = err_q;
endmodule
